// File: rtl/fsm.sv
// -----------------------------------------------------------------------------
// fsm -- Pong game-flow controller.
//
// Owns the ball position/direction, detects left/right wall collisions, keeps
// both players' scores and sequences IDLE -> PLAY -> POINT -> IDLE/GAME_OVER.
//
// Ports:
//   clk          system clock, rising edge
//   sim_rst      asynchronous active-low reset
//   btn_fire     debounced fire button (synchronous level)
//   ball_x       ball left edge x (10 bits)
//   ball_y       ball top edge y (10 bits)
//   score_left   left player score (4 bits)
//   score_right  right player score (4 bits)
//   game_over    high while in GAME_OVER
//   state_o      current state encoding (IDLE=00 PLAY=01 POINT=10 GAME_OVER=11)
//
// Optional feature macro: FSM_AUTO_SERVE_EN -- when defined, the ball is served
// automatically after SERVE_DELAY consecutive IDLE cycles.
// -----------------------------------------------------------------------------
module fsm #(
    parameter int unsigned FIELD_W     = 640,
    parameter int unsigned FIELD_H     = 480,
    parameter int unsigned BALL_SIZE   = 8,
    parameter int unsigned MOVE_DIV    = 1,
    parameter int unsigned WIN_SCORE   = 5,
    parameter int unsigned SERVE_DELAY = 16
) (
    input  logic       clk,
    input  logic       sim_rst,
    input  logic       btn_fire,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       game_over,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PLAY      = 2'b01,
        POINT     = 2'b10,
        GAME_OVER = 2'b11
    } state_t;

    localparam logic [9:0] X_CENTRE = 10'(FIELD_W / 2 - BALL_SIZE / 2);
    localparam logic [9:0] Y_CENTRE = 10'(FIELD_H / 2 - BALL_SIZE / 2);
    localparam logic [9:0] X_MAX    = 10'(FIELD_W - BALL_SIZE);
    localparam logic [9:0] Y_MAX    = 10'(FIELD_H - BALL_SIZE);
    localparam logic [3:0] WIN      = 4'(WIN_SCORE);

    localparam int unsigned          DIV_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(MOVE_DIV - 1);

    // Reject parameter values the game logic cannot honour.
    if (MOVE_DIV < 1 || WIN_SCORE < 1 || WIN_SCORE > 15 || SERVE_DELAY < 1) begin : g_param_check
        $error("fsm: illegal parameter value");
    end

    state_t           state;
    logic             colEsquerda;
    logic             colDireita;
    logic [9:0]       r_ball_x;
    logic [9:0]       r_ball_y;
    logic             r_dx_neg;     // 1: ball moving left (dx=-1)
    logic             r_dy_neg;     // 1: ball moving up   (dy=-1)
    logic [3:0]       r_score_l;
    logic [3:0]       r_score_r;
    logic             r_game_over;
    logic [DIV_W-1:0] r_div;

`ifdef FSM_AUTO_SERVE_EN
    localparam int unsigned      SRV_W    = $clog2(SERVE_DELAY) + 1;
    localparam logic [SRV_W-1:0] SRV_LAST = SRV_W'(SERVE_DELAY - 1);
    logic [SRV_W-1:0] r_serve_cnt;
`endif

    logic       w_tick;
    logic [9:0] w_step_x;
    logic [9:0] w_step_y;
    logic [9:0] w_nx;
    logic [9:0] w_ny;

    always_comb begin
        w_tick   = (r_div == DIV_LAST);
        w_step_x = r_dx_neg ? r_ball_x - 10'd1 : r_ball_x + 10'd1;
        w_step_y = r_dy_neg ? r_ball_y - 10'd1 : r_ball_y + 10'd1;
        w_nx     = w_tick ? w_step_x : r_ball_x;
        w_ny     = w_tick ? w_step_y : r_ball_y;
    end

    always_ff @(posedge clk or negedge sim_rst) begin
        if (!sim_rst) begin
            state       <= IDLE;
            colEsquerda <= 1'b0;
            colDireita  <= 1'b0;
            r_ball_x    <= X_CENTRE;
            r_ball_y    <= Y_CENTRE;
            r_dx_neg    <= 1'b1;
            r_dy_neg    <= 1'b0;
            r_score_l   <= '0;
            r_score_r   <= '0;
            r_game_over <= 1'b0;
            r_div       <= '0;
`ifdef FSM_AUTO_SERVE_EN
            r_serve_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    r_ball_x    <= X_CENTRE;
                    r_ball_y    <= Y_CENTRE;
                    colEsquerda <= 1'b0;
                    colDireita  <= 1'b0;
                    r_div       <= '0;
                    r_game_over <= 1'b0;
`ifdef FSM_AUTO_SERVE_EN
                    if (btn_fire || r_serve_cnt == SRV_LAST) begin
                        state       <= PLAY;
                        r_serve_cnt <= '0;
                    end else begin
                        r_serve_cnt <= r_serve_cnt + SRV_W'(1);
                    end
`else
                    if (btn_fire) state <= PLAY;
`endif
                end

                PLAY: begin
                    if (colEsquerda) begin
                        state       <= POINT;
                        colEsquerda <= 1'b0;
                        colDireita  <= 1'b0;
                        r_dx_neg    <= 1'b0;
                        if (r_score_r < WIN) r_score_r <= r_score_r + 4'd1;
                    end else if (colDireita) begin
                        state       <= POINT;
                        colEsquerda <= 1'b0;
                        colDireita  <= 1'b0;
                        r_dx_neg    <= 1'b1;
                        if (r_score_l < WIN) r_score_l <= r_score_l + 4'd1;
                    end else begin
                        r_div    <= w_tick ? '0 : r_div + DIV_W'(1);
                        r_ball_x <= w_nx;
                        r_ball_y <= w_ny;
                        // Bounce off top/bottom in the same edge the wall is reached.
                        if (w_tick && (w_step_y == '0 || w_step_y == Y_MAX))
                            r_dy_neg <= ~r_dy_neg;
                        colEsquerda <= (w_nx == '0);
                        colDireita  <= (w_nx == X_MAX);
                    end
                end

                POINT: begin
                    r_ball_x    <= X_CENTRE;
                    r_ball_y    <= Y_CENTRE;
                    colEsquerda <= 1'b0;
                    colDireita  <= 1'b0;
                    r_dy_neg    <= 1'b0;
                    r_div       <= '0;
                    if (r_score_l == WIN || r_score_r == WIN) begin
                        state       <= GAME_OVER;
                        r_game_over <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end

                GAME_OVER: begin
                    r_ball_x    <= X_CENTRE;
                    r_ball_y    <= Y_CENTRE;
                    colEsquerda <= 1'b0;
                    colDireita  <= 1'b0;
                    r_div       <= '0;
                    if (btn_fire) begin
                        state       <= IDLE;
                        r_game_over <= 1'b0;
                        r_score_l   <= '0;
                        r_score_r   <= '0;
                        r_dx_neg    <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign ball_x      = r_ball_x;
    assign ball_y      = r_ball_y;
    assign score_left  = r_score_l;
    assign score_right = r_score_r;
    assign game_over   = r_game_over;
    assign state_o     = state;

endmodule

// File: tb/tb_fsm.sv
// -----------------------------------------------------------------------------
// tb_fsm -- self-checking bench for the Pong game-flow controller.
// A game model (integer positions, signed velocities) predicts every output;
// a compare process checks it each falling edge, and directed sequences add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_fsm;

    localparam int W     = 640;
    localparam int H     = 480;
    localparam int B     = 8;
    localparam int DIV   = 1;
    localparam int WINS  = 5;
    localparam int SDLY  = 16;
    localparam int XC    = W / 2 - B / 2;   // 316
    localparam int YC    = H / 2 - B / 2;   // 236

    logic       clk = 1'b0;
    logic       sim_rst;
    logic       btn_fire;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic       game_over;
    logic [1:0] state_o;

    fsm #(
        .FIELD_W    (W),
        .FIELD_H    (H),
        .BALL_SIZE  (B),
        .MOVE_DIV   (DIV),
        .WIN_SCORE  (WINS),
        .SERVE_DELAY(SDLY)
    ) dut (
        .clk        (clk),
        .sim_rst    (sim_rst),
        .btn_fire   (btn_fire),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .score_left (score_left),
        .score_right(score_right),
        .game_over  (game_over),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit checking = 1'b0;

    function automatic void chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- game model ----------------
    // mode: 0 waiting for serve, 1 rally, 2 point scored, 3 match over
    int m_mode, m_x, m_y, m_vx, m_vy, m_sl, m_sr, m_div, m_idle;
    bit m_hitL, m_hitR;

    task automatic model_reset();
        m_mode = 0; m_x = XC; m_y = YC; m_vx = -1; m_vy = 1;
        m_sl = 0; m_sr = 0; m_div = 0; m_idle = 0;
        m_hitL = 1'b0; m_hitR = 1'b0;
    endtask

    task automatic model_step();
        bit serve;
        case (m_mode)
            0: begin
                serve = btn_fire;
`ifdef FSM_AUTO_SERVE_EN
                if (m_idle == SDLY - 1) serve = 1'b1;
                m_idle = serve ? 0 : m_idle + 1;
`endif
                if (serve) begin m_mode = 1; m_div = 0; end
            end
            1: begin
                if (m_hitL) begin
                    if (m_sr < WINS) m_sr++;
                    m_vx = 1; m_mode = 2; m_hitL = 0; m_hitR = 0;
                end else if (m_hitR) begin
                    if (m_sl < WINS) m_sl++;
                    m_vx = -1; m_mode = 2; m_hitL = 0; m_hitR = 0;
                end else begin
                    m_div++;
                    if (m_div == DIV) begin
                        m_div = 0;
                        m_x += m_vx;
                        m_y += m_vy;
                        if (m_y == 0 || m_y == H - B) m_vy = -m_vy;
                    end
                    m_hitL = (m_x == 0);
                    m_hitR = (m_x == W - B);
                end
            end
            2: begin
                m_x = XC; m_y = YC; m_vy = 1;
                m_mode = (m_sl == WINS || m_sr == WINS) ? 3 : 0;
            end
            default: begin
                if (btn_fire) begin m_mode = 0; m_sl = 0; m_sr = 0; m_vx = -1; end
            end
        endcase
    endtask

    always @(posedge clk or negedge sim_rst) begin
        if (!sim_rst) model_reset();
        else          model_step();
    end

    always @(negedge clk) begin
        if (checking && sim_rst === 1'b1) begin
            chk("state_o",     int'(state_o),     m_mode);
            chk("ball_x",      int'(ball_x),      m_x);
            chk("ball_y",      int'(ball_y),      m_y);
            chk("score_left",  int'(score_left),  m_sl);
            chk("score_right", int'(score_right), m_sr);
            chk("game_over",   int'(game_over),   (m_mode == 3) ? 1 : 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 sim_rst = 1'b0;
        #2 sim_rst = 1'b1;
    endtask

    task automatic serve();
        btn_fire = 1'b1;
        step(1);
        btn_fire = 1'b0;
    endtask

    task automatic deposit(input bit left, input bit right);
        if (left)  begin dut.colEsquerda = 1'b1; m_hitL = 1'b1; end
        if (right) begin dut.colDireita  = 1'b1; m_hitR = 1'b1; end
    endtask

    task automatic check_centre(input string tag);
        chk({tag, "_x"}, int'(ball_x), 316);
        chk({tag, "_y"}, int'(ball_y), 236);
    endtask

    initial begin
        bit found;
        int maxy;

        sim_rst  = 1'b1;
        btn_fire = 1'b0;
        #1 sim_rst = 1'b0;
        #10;
        chk("rst_state", int'(state_o), 0);
        check_centre("rst");
        chk("rst_sl", int'(score_left), 0);
        chk("rst_sr", int'(score_right), 0);
        chk("rst_go", int'(game_over), 0);
        #1 sim_rst = 1'b1;
        checking = 1'b1;

        // Idle holds after reset
        step(2);
        chk("idle_state", int'(state_o), 0);
        check_centre("idle");

        // Serve, then first move
        serve();
        chk("serve_state", int'(state_o), 1);
        check_centre("serve");
        step(1);
        chk("move1_state", int'(state_o), 1);
        chk("move1_x", int'(ball_x), 315);
        chk("move1_y", int'(ball_y), 237);

        // Deposited left collision
        deposit(1'b1, 1'b0);
        step(1);
        chk("dep_point_state", int'(state_o), 2);
        chk("dep_point_sr", int'(score_right), 1);
        step(1);
        chk("dep_idle_state", int'(state_o), 0);
        check_centre("dep_idle");

        // Natural travel to the left wall from reset
        do_reset();
        serve();
        found = 1'b0; maxy = 0;
        for (int i = 0; i < 400; i++) begin
            step(1);
            if (int'(ball_y) > maxy) maxy = int'(ball_y);
            if (ball_x == 10'd0) begin found = 1'b1; break; end
        end
        chk("left_wall_reached", int'(found), 1);
        chk("left_wall_flag", int'(dut.colEsquerda), 1);
        chk("left_wall_y", int'(ball_y), 392);
        chk("bottom_bounce_max_y", maxy, 472);
        step(1);
        chk("lw_point_state", int'(state_o), 2);
        chk("lw_point_sr", int'(score_right), 1);
        step(1);
        chk("lw_idle_state", int'(state_o), 0);

        // Natural travel to the right wall (serve direction is now +x)
        serve();
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step(1);
            if (ball_x == 10'd632) begin found = 1'b1; break; end
        end
        chk("right_wall_reached", int'(found), 1);
        chk("right_wall_flag", int'(dut.colDireita), 1);
        chk("right_wall_y", int'(ball_y), 392);
        step(1);
        chk("rw_point_state", int'(state_o), 2);
        chk("rw_point_sl", int'(score_left), 1);
        step(1);

        // Both flags: left wins
        serve();
        deposit(1'b1, 1'b1);
        step(1);
        chk("prio_sr", int'(score_right), 2);
        chk("prio_sl", int'(score_left), 1);
        step(1);

        // Five left-wall points end the game
        do_reset();
        for (int p = 0; p < 5; p++) begin
            serve();
            deposit(1'b1, 1'b0);
            step(2);
        end
        chk("go_state", int'(state_o), 3);
        chk("go_flag", int'(game_over), 1);
        chk("go_sr", int'(score_right), 5);
        check_centre("go");
        step(2);
        chk("go_hold_state", int'(state_o), 3);
        btn_fire = 1'b1;
        step(1);
        btn_fire = 1'b0;
        chk("restart_state", int'(state_o), 0);
        chk("restart_sl", int'(score_left), 0);
        chk("restart_sr", int'(score_right), 0);
        chk("restart_go", int'(game_over), 0);

        // Asynchronous reset mid-rally
        do_reset();
        serve();
        step(4);
        chk("midplay_x", int'(ball_x), 312);
        chk("midplay_y", int'(ball_y), 240);
        #4 sim_rst = 1'b0;
        #1;
        chk("async_state", int'(state_o), 0);
        check_centre("async");
        chk("async_go", int'(game_over), 0);
        #2 sim_rst = 1'b1;

        // Auto-serve timing (stays idle when the feature is absent)
        do_reset();
        step(15);
        chk("autoserve_15", int'(state_o), 0);
        step(1);
`ifdef FSM_AUTO_SERVE_EN
        chk("autoserve_16", int'(state_o), 1);
`else
        chk("no_autoserve_16", int'(state_o), 0);
`endif
        step(3);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fsm.md
Name: fsm

Overview:
- Game-flow controller for the Pong project.
- Owns the ball position and direction, detects left and right wall collisions, and keeps both players' scores.
- Sequences the game through idle, play, point and game-over.
- Sits between the fire button synchroniser and the VGA renderer, which consumes the ball and score outputs.

Parameters:
- FIELD_W, 640, playfield width in pixels.
- FIELD_H, 480, playfield height in pixels.
- BALL_SIZE, 8, ball edge length in pixels.
- MOVE_DIV, 1, clocks per ball movement tick (>=1).
- WIN_SCORE, 5, score that ends the game (1..15).
- SERVE_DELAY, 16, idle clocks before auto-serve (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- sim_rst  in  1  reset, asynchronous, active-low.
- btn_fire  in  1  fire button, synchronous level, already debounced.
- ball_x  out  10  ball left edge x.
- ball_y  out  10  ball top edge y.
- score_left  out  4  left player score.
- score_right  out  4  right player score.
- game_over  out  1  high while in GAME_OVER.
- state_o  out  2  current state encoding.

Port order is exactly as listed above. The first three ports must connect positionally.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- State register is named `state`, 2 bits:
  - IDLE=00
  - PLAY=01
  - POINT=10
  - GAME_OVER=11
- Collision flags are registers named `colEsquerda` (left) and `colDireita` (right). Next-state logic reads the registered values, so a value deposited into them by a bench is honoured at the following edge.
- Reset (sim_rst=0, immediate, also mid-operation):
  - state=IDLE
  - ball_x=FIELD_W/2-BALL_SIZE/2 (316), ball_y=FIELD_H/2-BALL_SIZE/2 (236)
  - dx=-1, dy=+1
  - scores=0, both collision flags=0, divider=0
- IDLE:
  - Ball held at centre.
  - btn_fire=1 at an edge -> PLAY at that edge.
- PLAY, ball movement:
  - Divider counts 0..MOVE_DIV-1. On wrap (the tick), ball_x+=dx and ball_y+=dy.
  - If new ball_y is 0 or FIELD_H-BALL_SIZE, dy flips at the same edge.
  - At every edge, colEsquerda<=(new ball_x==0) and colDireita<=(new ball_x==FIELD_W-BALL_SIZE).
  - Ball does not move while either flag is set.
- PLAY, exit on collision:
  - colEsquerda=1 -> POINT; score_right+1 (saturating at WIN_SCORE); next dx=+1.
  - Else colDireita=1 -> POINT; score_left+1; next dx=-1.
  - Left has priority if both flags are set.
  - btn_fire is ignored in PLAY.
- POINT (exactly one cycle):
  - Ball recentred, flags cleared, dy=+1.
  - Either score ==WIN_SCORE -> GAME_OVER, else -> IDLE.
- GAME_OVER:
  - game_over=1, ball held at centre.
  - btn_fire=1 -> IDLE with both scores cleared and dx=-1.
- Outside PLAY, both collision flags are forced to 0 each edge.
- All outputs are registered.
- state_o mirrors state.

Optional Feature:
- Macro: FSM_AUTO_SERVE_EN.
- When defined:
  - A counter runs in IDLE only.
  - After SERVE_DELAY consecutive IDLE cycles, the FSM enters PLAY without btn_fire. btn_fire still serves immediately.
  - The counter clears on leaving IDLE and on reset.
- When undefined: IDLE leaves only on btn_fire; no counter logic is present.

Test Plan:
- Reset pulse, then 2 clocks with btn_fire=0 -> state=00, ball=(316,236), scores 0/0, game_over=0.
- btn_fire=1 for one edge -> state=01. Then btn_fire=0, one edge -> state=01, ball=(315,237).
- In PLAY, deposit colEsquerda=1, one edge -> state=10, score_right=1. Next edge -> state=00, ball=(316,236).
- Natural travel, MOVE_DIV=1, serve from reset:
  - The edge moving ball_x to 0 sets colEsquerda.
  - Next edge -> POINT, score_right=1.
  - dy flips whenever ball_y reaches 0 or 472.
- Five left-wall points -> state=11, game_over=1, score_right=5. btn_fire=1 -> state=00, scores 0/0.
- Assert sim_rst=0 mid-PLAY between edges -> outputs return to reset values immediately, before any clock edge. With FSM_AUTO_SERVE_EN: 16 idle cycles -> state=01.
